// File: rtl/zx_video_gen_if.sv
// rtl/zx_video_gen_if.sv - VRAM-side port of zx_video_gen: fetch address, data, floating bus, contention.
interface zx_video_gen_if;
  logic [13:0] a;
  logic [7:0]  d;
  logic [7:0]  bus;
  logic        contend;

  modport master (output a, bus, contend, input d);
  modport slave  (input a, bus, contend, output d);
endinterface

// File: rtl/zx_video_gen.sv
// rtl/zx_video_gen.sv - parametrised Spectrum video generator: raster, VRAM fetch, contention, IRQ, sync, RGBI.
// Optional macro FLOATBUS_EN drives vram.bus with the byte on the fetch path during active cells.
module zx_video_gen #(
  parameter int H_TOTAL    = 456,
  parameter int V_TOTAL    = 311,
  parameter int IRQ_LINE   = 248,
  parameter int IRQ_BEG    = 6,
  parameter int IRQ_LEN    = 72,
  parameter int HBLANK_BEG = 320,
  parameter int HSYNC_BEG  = 344,
  parameter int VSYNC_BEG  = 248
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic [2:0]    border,
  input  logic          mode,
  zx_video_gen_if.master vram,
  output logic          irq,
  output logic          hblank,
  output logic          vblank,
  output logic          hsync,
  output logic          vsync,
  output logic          r,
  output logic          g,
  output logic          b,
  output logic          i
);
  // Counters are at least 9/8 bits wide so the address bit slices always exist.
  localparam int HW = ($clog2(H_TOTAL) < 9) ? 9 : $clog2(H_TOTAL);
  localparam int VW = ($clog2(V_TOTAL) < 8) ? 8 : $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(256);
  localparam logic [VW-1:0] V_ACT   = VW'(192);
  localparam logic [VW-1:0] IRQ_V   = VW'(IRQ_LINE);
  localparam logic [HW-1:0] IRQ_H0  = HW'(IRQ_BEG);
  localparam logic [HW-1:0] IRQ_H1  = HW'(IRQ_BEG + IRQ_LEN);
  localparam logic [HW-1:0] HB_BEG  = HW'(HBLANK_BEG);
  localparam logic [HW-1:0] HB_END  = HW'(HBLANK_BEG + 96);
  localparam logic [HW-1:0] HS_BEG  = HW'(HSYNC_BEG);
  localparam logic [HW-1:0] HS_END  = HW'(HSYNC_BEG + 32);
  localparam logic [VW-1:0] VB_BEG  = VW'(VSYNC_BEG);
  localparam logic [VW-1:0] VB_END  = VW'(VSYNC_BEG + 8);
  localparam logic [VW-1:0] VS_END  = VW'(VSYNC_BEG + 4);

  logic [HW-1:0] h_count;
  logic [VW-1:0] v_count;
  logic [4:0]    f_count;
  logic          mode_q;
  logic          video_en;
  logic [7:0]    pix_byte;
  logic [7:0]    attr_byte;
  logic [7:0]    shifter;
  logic [7:0]    attr;
  logic          data_en;
  logic          pixel;
  logic [13:0]   pix_addr;
  logic [13:0]   attr_addr;

  assign data_en = (h_count < H_ACT) && (v_count < V_ACT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_count   <= '0;
      v_count   <= '0;
      f_count   <= '0;
      mode_q    <= 1'b0;
      video_en  <= 1'b0;
      pix_byte  <= 8'h00;
      attr_byte <= 8'h00;
      shifter   <= 8'h00;
      attr      <= 8'h00;
    end else if (ce) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        if (v_count == V_LAST) begin
          v_count <= '0;
          f_count <= f_count + 5'd1;
        end else begin
          v_count <= v_count + 1'b1;
        end
      end else begin
        h_count <= h_count + 1'b1;
      end

      if (h_count[3:0] == 4'd0)
        mode_q <= mode;

      // Odd ticks of the upper half-cell capture the byte addressed on the previous tick.
      if (data_en && h_count[3] && h_count[0]) begin
        if (h_count[1])
          attr_byte <= vram.d;
        else
          pix_byte <= vram.d;
      end

      if (h_count[3])
        video_en <= data_en;

      if (h_count[2:0] == 3'd4) begin
        shifter <= video_en ? pix_byte : 8'h00;
        attr    <= video_en ? attr_byte : {2'b00, border, 3'b000};
      end else begin
        shifter <= {shifter[6:0], 1'b0};
      end
    end
  end

  assign pix_addr  = {1'b0, v_count[7:6], v_count[2:0], v_count[5:3], h_count[7:4], h_count[2]};
  assign attr_addr = mode_q ? (pix_addr | 14'h2000)
                            : {1'b0, 3'b110, v_count[7:6], v_count[5:3], h_count[7:4], h_count[2]};
  assign vram.a       = h_count[1] ? attr_addr : pix_addr;
  assign vram.contend = data_en && (h_count[3] | h_count[2]);

`ifdef FLOATBUS_EN
  // Ticks 9..15: the live byte on capture ticks, the last captured byte in between.
  always_comb begin
    vram.bus = 8'hFF;
    if (data_en && h_count[3] && (h_count[2:0] != 3'd0)) begin
      if (h_count[0])
        vram.bus = vram.d;
      else if (h_count[2:1] == 2'b10)
        vram.bus = attr_byte;
      else
        vram.bus = pix_byte;
    end
  end
`else
  assign vram.bus = 8'hFF;
`endif

  assign irq    = !((v_count == IRQ_V) && (h_count >= IRQ_H0) && (h_count < IRQ_H1));
  assign hblank = (h_count >= HB_BEG) && (h_count < HB_END);
  assign hsync  = (h_count >= HS_BEG) && (h_count < HS_END);
  assign vblank = (v_count >= VB_BEG) && (v_count < VB_END);
  assign vsync  = (v_count >= VB_BEG) && (v_count < VS_END);

  assign pixel     = shifter[7] ^ (f_count[4] & attr[7]);
  assign {g, r, b} = pixel ? attr[2:0] : attr[5:3];
  assign i         = attr[6];
endmodule

// File: tb/tb_zx_video_gen.sv
// tb/tb_zx_video_gen.sv - directed bench: dut_a uses 48K timing, dut_b a short frame so IRQ/vsync/flash fit.
module tb_zx_video_gen;
  localparam int A_H = 456, A_V = 311, A_VS = 248;
  localparam int B_H = 448, B_V = 9, B_IRQ = 2, B_VS = 1;

`ifdef FLOATBUS_EN
  localparam logic [7:0] BUS_ACT = 8'h5C;
`else
  localparam logic [7:0] BUS_ACT = 8'hFF;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic       mode = 1'b0;
  logic [2:0] border = 3'b010;
  logic [7:0] a_val = 8'h5C;
  logic [7:0] pix_val = 8'hAA;
  logic [7:0] attr_val = 8'h47;

  logic irq_a, hblank_a, vblank_a, hsync_a, vsync_a, r_a, g_a, b_a, i_a;
  logic irq_b, hblank_b, vblank_b, hsync_b, vsync_b, r_b, g_b, b_b, i_b;
  logic [3:0] rgbi_a, rgbi_b;
  int tk = 0;
  int vecs = 0;
  int fails = 0;

  zx_video_gen_if ifa();
  zx_video_gen_if ifb();

  assign rgbi_a = {r_a, g_a, b_a, i_a};
  assign rgbi_b = {r_b, g_b, b_b, i_b};

  zx_video_gen #(.H_TOTAL(A_H), .V_TOTAL(A_V)) dut_a (
    .clock(clock), .reset(reset), .ce(ce), .border(border), .mode(mode), .vram(ifa),
    .irq(irq_a), .hblank(hblank_a), .vblank(vblank_a), .hsync(hsync_a), .vsync(vsync_a),
    .r(r_a), .g(g_a), .b(b_a), .i(i_a)
  );

  zx_video_gen #(.H_TOTAL(B_H), .V_TOTAL(B_V), .IRQ_LINE(B_IRQ), .VSYNC_BEG(B_VS)) dut_b (
    .clock(clock), .reset(reset), .ce(ce), .border(border), .mode(mode), .vram(ifb),
    .irq(irq_b), .hblank(hblank_b), .vblank(vblank_b), .hsync(hsync_b), .vsync(vsync_b),
    .r(r_b), .g(g_b), .b(b_b), .i(i_b)
  );

  always #5 clock = ~clock;

  // tk = number of ce ticks since reset release, i.e. the raster position of both DUTs.
  always @(posedge clock or posedge reset)
    if (reset) tk <= 0;
    else if (ce) tk <= tk + 1;

  // VRAM model: data returned one tick after the address; dut_b splits bitmap and attribute areas.
  always @(posedge clock)
    if (ce) begin
      ifa.d <= a_val;
      ifb.d <= (ifb.a >= 14'h1800) ? attr_val : pix_val;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic at(input int n);
    int guard = 0;
    while (tk < n && guard < 100000) begin
      @(negedge clock);
      guard++;
    end
    if (tk < n) chk("wait_timeout", tk, n);
  endtask

  initial begin
    int first_low;
    int low_cnt;
    if (A_H < 448 || B_H < 448 || A_V < A_VS + 8 || B_V < B_VS + 8) begin
      $display("FAIL param_check: geometry outside supported range");
      $fatal(1);
    end

    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset in the middle of dut_b's IRQ pulse must end the pulse at once.
    at(920);
    chk("irq_b_mid_pulse", irq_b, 1'b0);
    reset = 1'b1;
    #1;
    chk("irq_b_after_reset", irq_b, 1'b1);
    chk("a_a_after_reset", ifa.a, 14'h0000);
    chk("rgbi_b_after_reset", rgbi_b, 4'b0000);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    chk("irq_a_reset", irq_a, 1'b1);
    chk("rgbi_a_reset", rgbi_a, 4'b0000);
    chk("bus_a_reset", ifa.bus, 8'hFF);
    chk("bus_b_reset", ifb.bus, 8'hFF);
    chk("blank_sync_a_reset", {hblank_a, hsync_a, vblank_a, vsync_a}, 4'b0000);
    chk("contend_a_reset", ifa.contend, 1'b0);

    at(3);  chk("contend_a_h3", ifa.contend, 1'b0);
    at(4);  chk("contend_a_h4", ifa.contend, 1'b1);
    at(8);  chk("rgbi_b_left_border", rgbi_b, 4'b1000);
    at(12); chk("rgbi_b_h12_border", rgbi_b, 4'b1000);
    at(13); chk("rgbi_b_h13_ink", rgbi_b, 4'b1111);
    at(14); chk("rgbi_b_h14_paper", rgbi_b, 4'b0001);

    ce = 1'b0;
    repeat (5) @(negedge clock);
    chk("rgbi_b_frozen", rgbi_b, 4'b0001);
    chk("a_a_frozen", ifa.a, 14'h1801);
    ce = 1'b1;

    at(15);  chk("rgbi_b_h15_ink", rgbi_b, 4'b1111);
    at(16);  chk("rgbi_b_h16_paper", rgbi_b, 4'b0001);
    at(100); chk("vsync_vblank_b_line0", {vsync_b, vblank_b}, 2'b00);
    at(255); chk("contend_a_h255", ifa.contend, 1'b1);
    at(256); chk("contend_a_h256", ifa.contend, 1'b0);
    at(268); chk("contend_a_h268", ifa.contend, 1'b0);
    at(300);
    chk("rgbi_b_right_border", rgbi_b, 4'b1000);
    chk("rgbi_a_right_border", rgbi_a, 4'b1000);
    at(319); chk("hblank_b_319", hblank_b, 1'b0);
    at(320);
    chk("hblank_b_320", hblank_b, 1'b1);
    chk("hblank_a_320", hblank_a, 1'b1);
    at(343); chk("hsync_b_343", hsync_b, 1'b0);
    at(344);
    chk("hsync_b_344", hsync_b, 1'b1);
    chk("hsync_a_344", hsync_a, 1'b1);
    at(375); chk("hsync_b_375", hsync_b, 1'b1);
    at(376); chk("hsync_b_376", hsync_b, 1'b0);
    at(415); chk("hblank_b_415", hblank_b, 1'b1);
    at(416); chk("hblank_b_416", hblank_b, 1'b0);
    at(548); chk("vsync_vblank_b_line1", {vsync_b, vblank_b}, 2'b11);

    first_low = -1;
    low_cnt = 0;
    for (int t = 880; t <= 1000; t++) begin
      at(t);
      if (irq_b === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = t;
      end
    end
    chk("irq_b_first_low", first_low, 902);
    chk("irq_b_low_len", low_cnt, 72);

    at(1892); chk("vsync_b_line4", vsync_b, 1'b1);
    at(2340); chk("vsync_vblank_b_line5", {vsync_b, vblank_b}, 2'b01);
    at(3684); chk("vblank_b_line8", vblank_b, 1'b1);
    at(4132); chk("vblank_b_next_frame", vblank_b, 1'b0);
    at(4933); chk("irq_b_before_next", irq_b, 1'b1);
    at(4934); chk("irq_b_next_frame", irq_b, 1'b0);
    attr_val = 8'hC7;

    // dut_a line 65 starts at tick 65*456 = 29640.
    at(29656); chk("a_a_pix_v65_h16", ifa.a, 14'h0902);
    at(29658); chk("a_a_attr_v65_h18", ifa.a, 14'h1902);
    at(29661); mode = 1'b1;
    at(29662); chk("a_a_attr_h22_mode_held", ifa.a, 14'h1903);
    at(29664); chk("bus_a_h8", ifa.bus, 8'hFF);
    at(29665); chk("bus_a_h9", ifa.bus, BUS_ACT);
    at(29666); chk("a_a_attr_h26_mode_held", ifa.a, 14'h1902);
    at(29668); chk("bus_a_h12", ifa.bus, BUS_ACT);
    at(29671); chk("bus_a_h15", ifa.bus, BUS_ACT);
    at(29672);
    chk("bus_a_h0", ifa.bus, 8'hFF);
    chk("a_a_pix_h32", ifa.a, 14'h0904);
    at(29674); chk("a_a_hicolour_h34", ifa.a, 14'h2904);
    at(29680); mode = 1'b0;
    at(29940); chk("bus_a_outside_active", ifa.bus, 8'hFF);

    // Frame 15 is the last without flash, frame 16 the first with it (4032 ticks per dut_b frame).
    at(60493); chk("rgbi_b_f15_ink", rgbi_b, 4'b1111);
    at(60494); chk("rgbi_b_f15_paper", rgbi_b, 4'b0001);
    at(64525); chk("rgbi_b_f16_flash_a", rgbi_b, 4'b0001);
    at(64526); chk("rgbi_b_f16_flash_b", rgbi_b, 4'b1111);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
